// File: rtl/vmon_pkg.sv
// rtl/vmon_pkg.sv - shared types, constants and helpers for the rail voltage monitor
package vmon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EVAL = 2'd2
    } vmon_state_e;

    function automatic int chsel_w(input int vrails);
        return (vrails > 1) ? $clog2(vrails) : 1;
    endfunction

    localparam int VMON_VRAILS_DEF = 4;
    localparam int VMON_CHSEL_W    = chsel_w(VMON_VRAILS_DEF);

    // Unsigned a - b clamped at zero; callers narrow the result to the sample width
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/vmon_pwrgd_gen_if.sv
// rtl/vmon_pwrgd_gen_if.sv - ADC request/acknowledge handshake between monitor and converter
interface vmon_pwrgd_gen_if #(
    parameter int ADC_WIDTH = 12,
    parameter int CHSEL_W   = 2
);
    logic                 adc_req;
    logic [CHSEL_W-1:0]   adc_chsel;
    logic                 adc_ack;
    logic [ADC_WIDTH-1:0] adc_data;

    modport master (
        output adc_req,
        output adc_chsel,
        input  adc_ack,
        input  adc_data
    );

    modport slave (
        input  adc_req,
        input  adc_chsel,
        output adc_ack,
        output adc_data
    );
endinterface

// File: rtl/vmon_rail_filter.sv
// rtl/vmon_rail_filter.sv - per-rail window qualifier with hysteresis, sample filter and sticky OV
module vmon_rail_filter
    import vmon_pkg::*;
#(
    parameter int ADC_WIDTH = 12,
    parameter int FILT_CNT  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena_i,
    input  logic                 eval_i,
    input  logic [ADC_WIDTH-1:0] sample_i,
    input  logic [ADC_WIDTH-1:0] uv_i,
    input  logic [ADC_WIDTH-1:0] ov_i,
    input  logic [ADC_WIDTH-1:0] hyst_i,
    input  logic                 clear_i,
    output logic                 pwrgd_o,
    output logic                 ov_o
);
    localparam int CNT_W = $clog2(FILT_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

    logic             pwrgd_q;
    logic             ov_q;
    logic [CNT_W-1:0] cnt_q;

    logic [ADC_WIDTH-1:0] uv_eff_d;
    logic                 in_window_d;
    logic                 over_d;

    // A good rail only drops once it falls below UV-HYST
    assign uv_eff_d    = pwrgd_q ? ADC_WIDTH'(sat_sub(32'(uv_i), 32'(hyst_i))) : uv_i;
    assign in_window_d = (sample_i >= uv_eff_d) && (sample_i <= ov_i);
    assign over_d      = sample_i > ov_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwrgd_q <= 1'b0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            if (!ena_i) begin
                pwrgd_q <= 1'b0;
                cnt_q   <= '0;
            end else if (eval_i) begin
                if (in_window_d != pwrgd_q) begin
                    if (cnt_q == CNT_LAST) begin
                        pwrgd_q <= ~pwrgd_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end

            // A fresh over-voltage sample wins over a simultaneous clear
            if (ena_i && eval_i && over_d) begin
                ov_q <= 1'b1;
            end else if (clear_i) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign pwrgd_o = pwrgd_q;
    assign ov_o    = ov_q;
endmodule

// File: rtl/vmon_pwrgd_gen.sv
// rtl/vmon_pwrgd_gen.sv - multi-rail voltage monitor: round-robin ADC polling and power-good generation
module vmon_pwrgd_gen
    import vmon_pkg::*;
#(
    parameter int VRAILS    = 4,
    parameter int ADC_WIDTH = 12,
    parameter int FILT_CNT  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [VRAILS-1:0]             vmon_ena_i,
    input  logic [VRAILS*ADC_WIDTH-1:0]   uv_thresh_i,
    input  logic [VRAILS*ADC_WIDTH-1:0]   ov_thresh_i,
    input  logic [ADC_WIDTH-1:0]          hyst_i,
    input  logic [VRAILS-1:0]             clear_ov_i,
    output logic [VRAILS-1:0]             vrail_pwrgd_o,
    output logic [VRAILS-1:0]             vrail_ov_o,
    vmon_pwrgd_gen_if.master              adc
);
    localparam int CW = chsel_w(VRAILS);

    vmon_state_e          state_q;
    logic [CW-1:0]        ptr_q;
    logic [CW-1:0]        chsel_q;
    logic                 req_q;
    logic [ADC_WIDTH-1:0] data_q;

    logic [2*VRAILS-1:0]  ena_dbl;
    logic [VRAILS-1:0]    ena_rot;
    logic [CW-1:0]        off_d;
    logic [CW:0]          sum_d;
    logic [CW-1:0]        next_ch_d;
    logic [CW-1:0]        ptr_inc_d;
    logic                 any_ena;

    // Rotate the enables so bit 0 is the pointer; the lowest set bit is the next channel
    assign ena_dbl = {vmon_ena_i, vmon_ena_i};
    assign ena_rot = VRAILS'(ena_dbl >> ptr_q);
    assign any_ena = |vmon_ena_i;

    always_comb begin
        off_d = '0;
        for (int i = VRAILS - 1; i >= 0; i--) begin
            if (ena_rot[i]) begin
                off_d = CW'(i);
            end
        end
        sum_d = {1'b0, ptr_q} + {1'b0, off_d};
        if (sum_d >= (CW+1)'(VRAILS)) begin
            sum_d = sum_d - (CW+1)'(VRAILS);
        end
        next_ch_d = sum_d[CW-1:0];
    end

    assign ptr_inc_d = (chsel_q == CW'(VRAILS - 1)) ? '0 : chsel_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            chsel_q <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_ena) begin
                        chsel_q <= next_ch_d;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (adc.adc_ack) begin
                        data_q  <= adc.adc_data;
                        req_q   <= 1'b0;
                        state_q <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    ptr_q   <= ptr_inc_d;
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign adc.adc_req   = req_q;
    assign adc.adc_chsel = chsel_q;

    for (genvar g = 0; g < VRAILS; g++) begin : g_rail
        logic eval_sel;
        assign eval_sel = (state_q == ST_EVAL) && (chsel_q == CW'(g));

        vmon_rail_filter #(
            .ADC_WIDTH (ADC_WIDTH),
            .FILT_CNT  (FILT_CNT)
        ) u_filter (
            .clk      (clk),
            .rst      (rst),
            .ena_i    (vmon_ena_i[g]),
            .eval_i   (eval_sel),
            .sample_i (data_q),
            .uv_i     (uv_thresh_i[g*ADC_WIDTH +: ADC_WIDTH]),
            .ov_i     (ov_thresh_i[g*ADC_WIDTH +: ADC_WIDTH]),
            .hyst_i   (hyst_i),
            .clear_i  (clear_ov_i[g]),
            .pwrgd_o  (vrail_pwrgd_o[g]),
            .ov_o     (vrail_ov_o[g])
        );
    end
endmodule

// File: tb/tb_vmon_pwrgd_gen.sv
// tb/tb_vmon_pwrgd_gen.sv - directed self-checking bench for vmon_pwrgd_gen
module tb_vmon_pwrgd_gen;
    import vmon_pkg::*;

    localparam int VR = 4;
    localparam int AW = 12;
    localparam int FC = 3;
    localparam int CW = chsel_w(VR);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [VR-1:0]    ena;
    logic [VR-1:0]    clr;
    logic [VR*AW-1:0] uv;
    logic [VR*AW-1:0] ov;
    logic [AW-1:0]    hyst;
    logic [VR-1:0]    pg;
    logic [VR-1:0]    ovf;

    vmon_pwrgd_gen_if #(.ADC_WIDTH(AW), .CHSEL_W(CW)) adc_if ();

    vmon_pwrgd_gen #(.VRAILS(VR), .ADC_WIDTH(AW), .FILT_CNT(FC)) dut (
        .clk           (clk),
        .rst           (rst),
        .vmon_ena_i    (ena),
        .uv_thresh_i   (uv),
        .ov_thresh_i   (ov),
        .hyst_i        (hyst),
        .clear_ov_i    (clr),
        .vrail_pwrgd_o (pg),
        .vrail_ov_o    (ovf),
        .adc           (adc_if.master)
    );

    int checks   = 0;
    int failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        adc_if.adc_ack  = 1'b0;
        adc_if.adc_data = '1;
        clr = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (adc_if.adc_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_req: adc_req=%b after 64 cycles, required 1", adc_if.adc_req);
        end
    endtask

    // Returns one cycle after the ACK edge, i.e. while the DUT is in EVAL
    task automatic serve(input logic [AW-1:0] d, output logic [CW-1:0] ch);
        bit ok;
        wait_req(ok);
        ch = adc_if.adc_chsel;
        adc_if.adc_ack  = 1'b1;
        adc_if.adc_data = d;
        step();
        adc_if.adc_ack  = 1'b0;
        adc_if.adc_data = '1;
    endtask

    task automatic test_reset();
        int seen;
        ena  = '0;
        uv   = '0;
        ov   = '0;
        hyst = '0;
        do_reset();
        checks++;
        if ({adc_if.adc_req, adc_if.adc_chsel} !== '0) begin
            failures++;
            $display("FAIL reset_adc: req/chsel=%b, required 0", {adc_if.adc_req, adc_if.adc_chsel});
        end
        checks++;
        if ({pg, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: pwrgd/ov=%b, required 0", {pg, ovf});
        end
        adc_if.adc_ack  = 1'b1;
        adc_if.adc_data = 12'hFFF;
        step();
        adc_if.adc_ack  = 1'b0;
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            if (adc_if.adc_req !== 1'b0) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL idle_no_req: req high for %0d cycles, required 0", seen);
        end
        checks++;
        if ({pg, ovf} !== '0) begin
            failures++;
            $display("FAIL idle_outputs: pwrgd/ov=%b, required 0", {pg, ovf});
        end
    endtask

    task automatic test_qualify();
        logic [CW-1:0] ch;
        uv   = {VR{12'h800}};
        ov   = {VR{12'hC00}};
        hyst = 12'h020;
        ena  = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            serve(12'hA00, ch);
            checks++;
            if (ch !== 2'd0) begin
                failures++;
                $display("FAIL qualify_chsel[%0d]: chsel=%0d, required 0", k, ch);
            end
            checks++;
            if (pg[0] !== 1'b0) begin
                failures++;
                $display("FAIL qualify_early[%0d]: pwrgd0=%b, required 0", k, pg[0]);
            end
            step();
            checks++;
            if (pg[0] !== (k == 2)) begin
                failures++;
                $display("FAIL qualify_pg[%0d]: pwrgd0=%b, required %b", k, pg[0], (k == 2));
            end
        end
    endtask

    task automatic test_hysteresis();
        logic [CW-1:0] ch;
        for (int k = 0; k < 5; k++) begin
            serve(12'h7F0, ch);
            step();
        end
        checks++;
        if (pg[0] !== 1'b1) begin
            failures++;
            $display("FAIL hyst_band: pwrgd0=%b, required 1", pg[0]);
        end
        serve(12'h7D0, ch);
        step();
        serve(12'hA00, ch);
        step();
        checks++;
        if (pg[0] !== 1'b1) begin
            failures++;
            $display("FAIL hyst_single_low: pwrgd0=%b, required 1", pg[0]);
        end
        for (int k = 0; k < 3; k++) begin
            serve(12'h7D0, ch);
            step();
            checks++;
            if (pg[0] !== (k < 2)) begin
                failures++;
                $display("FAIL hyst_fall[%0d]: pwrgd0=%b, required %b", k, pg[0], (k < 2));
            end
        end
        for (int k = 0; k < 3; k++) begin
            serve(12'hA00, ch);
            step();
        end
        checks++;
        if (pg[0] !== 1'b1) begin
            failures++;
            $display("FAIL hyst_requalify: pwrgd0=%b, required 1", pg[0]);
        end
    endtask

    task automatic test_over_voltage();
        logic [CW-1:0] ch;
        serve(12'hC01, ch);
        checks++;
        if (ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL ov_early: ov0=%b, required 0", ovf[0]);
        end
        step();
        checks++;
        if ({ovf[0], pg[0]} !== 2'b11) begin
            failures++;
            $display("FAIL ov_set: ov0/pg0=%b, required 11", {ovf[0], pg[0]});
        end
        clr = 4'b0001;
        step();
        clr = '0;
        checks++;
        if (ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL ov_clear: ov0=%b, required 0", ovf[0]);
        end
        serve(12'hC01, ch);
        clr = 4'b0001;
        step();
        clr = '0;
        checks++;
        if ({ovf[0], pg[0]} !== 2'b11) begin
            failures++;
            $display("FAIL ov_set_beats_clear: ov0/pg0=%b, required 11", {ovf[0], pg[0]});
        end
        serve(12'hC01, ch);
        step();
        checks++;
        if ({ovf[0], pg[0]} !== 2'b10) begin
            failures++;
            $display("FAIL ov_filter_trip: ov0/pg0=%b, required 10", {ovf[0], pg[0]});
        end
    endtask

    task automatic test_round_robin();
        logic [CW-1:0] ch;
        logic [CW-1:0] exp_ch;
        do_reset();
        ena = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            exp_ch = (k % 2 == 0) ? 2'd1 : 2'd3;
            serve(12'hA00, ch);
            checks++;
            if (ch !== exp_ch) begin
                failures++;
                $display("FAIL rr_chsel[%0d]: chsel=%0d, required %0d", k, ch, exp_ch);
            end
        end
        step();
        checks++;
        if (pg !== 4'b1010) begin
            failures++;
            $display("FAIL rr_pwrgd: pwrgd=%b, required 1010", pg);
        end
    endtask

    task automatic test_mid_operation();
        bit ok;
        wait_req(ok);
        checks++;
        if (adc_if.adc_chsel !== 2'd1) begin
            failures++;
            $display("FAIL mid_chsel1: chsel=%0d, required 1", adc_if.adc_chsel);
        end
        ena = 4'b1000;
        step();
        checks++;
        if (pg !== 4'b1000) begin
            failures++;
            $display("FAIL mid_disable_pg: pwrgd=%b, required 1000", pg);
        end
        adc_if.adc_ack  = 1'b1;
        adc_if.adc_data = 12'hC01;
        step();
        adc_if.adc_ack  = 1'b0;
        adc_if.adc_data = '1;
        step();
        checks++;
        if ({ovf, pg} !== 8'b0000_1000) begin
            failures++;
            $display("FAIL mid_discard: ov/pwrgd=%b, required 00001000", {ovf, pg});
        end
        wait_req(ok);
        checks++;
        if (adc_if.adc_chsel !== 2'd3) begin
            failures++;
            $display("FAIL mid_next_chsel: chsel=%0d, required 3", adc_if.adc_chsel);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({adc_if.adc_req, pg} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset: req/pwrgd=%b, required 00000", {adc_if.adc_req, pg});
        end
        step();
        rst = 1'b0;
    endtask

    initial begin
        ena  = '0;
        clr  = '0;
        uv   = '0;
        ov   = '0;
        hyst = '0;
        adc_if.adc_ack  = 1'b0;
        adc_if.adc_data = '1;
        test_reset();
        test_qualify();
        test_hysteresis();
        test_over_voltage();
        test_round_robin();
        test_mid_operation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

// File: doc/vmon_pwrgd_gen.md
Name: vmon_pwrgd_gen

Overview:
- Multi-rail voltage monitor; the responder end of the rail enable / power-good interface.
- Consumes per-rail VMON_ENA from the sequencer and polls an external ADC through a REQ/ACK handshake, one channel at a time, round-robin.
- Qualifies each sample against per-rail UV/OV windows with hysteresis and a consecutive-sample filter.
- Drives VRAIL_PWRGD back to the sequencer, plus sticky per-rail over-voltage flags.

Parameters:
- VRAILS, 4, number of monitored rails (1..16).
- ADC_WIDTH, 12, ADC sample width.
- FILT_CNT, 3, consecutive disagreeing samples required to flip a rail's power-good state (1..15).

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- VMON_ENA  in  VRAILS  per-rail monitor enable from sequencer.
- UV_THRESH  in  VRAILS*ADC_WIDTH  per-rail under-voltage threshold; rail i at [i*ADC_WIDTH +: ADC_WIDTH].
- OV_THRESH  in  VRAILS*ADC_WIDTH  per-rail over-voltage threshold, same packing.
- HYST  in  ADC_WIDTH  falling hysteresis applied to UV once a rail is good.
- ADC_REQ  out  1  conversion request.
- ADC_CHSEL  out  max(1,$clog2(VRAILS))  channel for current request.
- ADC_ACK  in  1  one-cycle strobe; ADC_DATA valid in this cycle.
- ADC_DATA  in  ADC_WIDTH  unsigned sample.
- CLEAR_OV  in  VRAILS  per-rail clear of sticky OV flag.
- VRAIL_PWRGD  out  VRAILS  qualified power good.
- VRAIL_OV  out  VRAILS  sticky over-voltage flag.

Behaviour:
- Reset values: ADC_REQ=0, ADC_CHSEL=0, VRAIL_PWRGD=0, VRAIL_OV=0, all filter counters=0, FSM=IDLE, round-robin pointer=0.
- FSM states:
  - IDLE: if any VMON_ENA bit is set, select the next enabled channel at or after the pointer (wrap modulo VRAILS), then go to REQ. Otherwise stay in IDLE.
  - REQ: ADC_REQ=1 with ADC_CHSEL held stable. On ADC_ACK, capture ADC_DATA, drop ADC_REQ the next cycle, go to EVAL. There is no timeout.
  - EVAL: one cycle; apply the rail update rules below, set pointer = channel+1 (wrap), return to IDLE.
- Latency: ACK at cycle t, EVAL at t+1, VRAIL_PWRGD/VRAIL_OV change visible at t+2. Minimum per-sample period is 3 cycles plus ADC latency.
- ADC_ACK outside REQ is ignored. ADC_DATA is sampled only in the ACK cycle.
- Rail update in EVAL, for channel c:
  - in_window = (data >= uv_eff) && (data <= OV).
  - uv_eff = UV when PWRGD[c]=0; otherwise UV-HYST, saturating at 0.
  - Sample disagrees when in_window != PWRGD[c]. A disagreeing sample increments cnt[c]. When cnt[c]+1 == FILT_CNT, PWRGD[c] toggles and cnt[c] is cleared.
  - An agreeing sample clears cnt[c].
  - data > OV sets VRAIL_OV[c] immediately (unfiltered).
- VMON_ENA[c]=0, evaluated every cycle: PWRGD[c] and cnt[c] are forced to 0 on the next clock. If this occurs while c is in REQ, the handshake completes normally and EVAL discards the sample; VRAIL_OV is not updated.
- CLEAR_OV[c] clears VRAIL_OV[c] on the next clock. A set in the same EVAL cycle takes priority over the clear.
- Disabled channels are skipped by the round-robin and are never requested.
- Threshold or HYST changes take effect at the next EVAL. No registering is required.
- Reset asserted mid-handshake: ADC_REQ drops asynchronously. The ADC is required to tolerate an abandoned request.
- Counter width: $clog2(FILT_CNT+1), saturating never needed since it is cleared at FILT_CNT.

Decomposition:
- Shared package vmon_pkg:
  - FSM state enum (IDLE, REQ, EVAL).
  - Constant for channel-select width.
  - Function for saturating subtract (UV-HYST).
- Sub-module vmon_rail_filter, generated VRAILS times. It contains the per-rail PWRGD, counter and OV flag. Inputs: enable, eval strobe, sample, thresholds, HYST, clear.
- The top level holds the FSM, round-robin arbiter and ADC handshake.

Test Plan:
- Reset/idle: VMON_ENA=0 -> ADC_REQ stays 0 for 100 cycles; all outputs 0.
- Power-up qualify (UV=0x800, OV=0xC00, HYST=0x20, FILT_CNT=3), rail 0 only enabled, ADC returns 0xA00:
  - PWRGD[0] rises 2 cycles after the third ACK, not earlier.
  - Every request has CHSEL=0.
- Hysteresis:
  - Rail good, samples 0x7F0 (inside UV-HYST band) x5 -> PWRGD stays 1.
  - Then 0x7D0 x3 -> PWRGD falls after the third sample.
  - Single 0x7D0 between good samples -> no change.
- Over-voltage:
  - Sample 0xC01 -> VRAIL_OV[c]=1 after 2 cycles while PWRGD persists until the filter trips.
  - CLEAR_OV pulse -> flag 0.
  - Simultaneous set and clear -> flag stays 1.
- Round-robin/skip: VMON_ENA=4'b1010 -> CHSEL sequence 1,3,1,3. Channels 0 and 2 are never requested.
- Mid-operation: deassert VMON_ENA[1] while REQ is pending on channel 1 -> handshake completes, PWRGD[1]=0 next clock, sample discarded. Async RESET during REQ -> ADC_REQ=0 immediately.
